// File: rtl/log_antilog_stage.sv
// ---------------------------------------------------------------------------
// log_antilog_stage
//
// Back end of the Mitchell log multiplier.  Takes the characteristic sum and
// the biased mantissa-fraction sum produced by the log-domain adder and turns
// them back into an approximate linear-domain product.  Two register stages
// (S1: exponent/mantissa renormalisation, S2: barrel shift into the product)
// with a valid/ready handshake on both sides.  A sideband tag and a
// zero-operand flag ride along with every transaction.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     input transaction valid
//   in_ready     stage can accept an input this cycle
//   in_sum_k     k1 + k2 (characteristic sum)
//   in_sum_x     x1_t + x2_t + 1, bit M_WIDTH is the fraction carry
//   in_zero      one of the operands was zero
//   in_tag       sideband tag, passed through unchanged
//   out_valid    product valid
//   out_ready    consumer accepts the product
//   out_product  approximate product, 2*DWIDTH bits
//   out_tag      tag belonging to out_product
// ---------------------------------------------------------------------------
module log_antilog_stage #(
    parameter int DWIDTH    = 16,
    parameter int M_WIDTH   = 6,
    parameter int TAG_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [$clog2(DWIDTH):0] in_sum_k,
    input  logic [M_WIDTH:0]        in_sum_x,
    input  logic                    in_zero,
    input  logic [TAG_WIDTH-1:0]    in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DWIDTH-1:0]     out_product,
    output logic [TAG_WIDTH-1:0]    out_tag
);

    localparam int KW = $clog2(DWIDTH) + 1;
    localparam int PW = 2 * DWIDTH;
    // One extra bit so the exponent/shift comparison never wraps.
    localparam int SW = KW + 1;
    localparam logic [SW-1:0] M_CONST = SW'(M_WIDTH);

    // Stage 1 state
    logic                 s1_valid_q, s1_valid_d;
    logic [KW-1:0]        s1_e_q,     s1_e_d;
    logic [M_WIDTH:0]     s1_mant_q,  s1_mant_d;
    logic                 s1_zero_q,  s1_zero_d;
    logic [TAG_WIDTH-1:0] s1_tag_q,   s1_tag_d;

    // Stage 2 (output) state
    logic                 s2_valid_q,   s2_valid_d;
    logic [PW-1:0]        s2_product_q, s2_product_d;
    logic [TAG_WIDTH-1:0] s2_tag_q,     s2_tag_d;

    logic                 s2_load;
    logic                 in_fire;
    logic [PW-1:0]        mant_ext;
    logic [SW-1:0]        e_ext;
    logic [PW-1:0]        shifted;

    // Flow control: the output register refills whenever it is empty or
    // being drained; S1 advances in lockstep with it, so S1 can accept a new
    // input whenever it is empty or its content is moving into S2.
    always_comb begin
        s2_load  = !s2_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_load;
        in_fire  = in_valid && in_ready;
    end

    // Stage 1: fold the fraction carry into the exponent and restore the
    // hidden leading one of the mantissa.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_e_d     = s1_e_q;
        s1_mant_d  = s1_mant_q;
        s1_zero_d  = s1_zero_q;
        s1_tag_d   = s1_tag_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            s1_e_d    = in_sum_k + KW'(in_sum_x[M_WIDTH]);
            s1_mant_d = {1'b1, in_sum_x[M_WIDTH-1:0]};
            s1_zero_d = in_zero;
            s1_tag_d  = in_tag;
        end
    end

    // Barrel shift: the mantissa carries M_WIDTH fraction bits, so the binary
    // point sits M_WIDTH places from the right.  Exponents below M_WIDTH shift
    // right and drop fraction bits (truncation, no rounding).
    always_comb begin
        mant_ext = PW'(s1_mant_q);
        e_ext    = {1'b0, s1_e_q};
        shifted  = '0;
        if (e_ext >= M_CONST) begin
            shifted = mant_ext << (e_ext - M_CONST);
        end else begin
            shifted = mant_ext >> (M_CONST - e_ext);
        end
    end

    // Stage 2: the output register only changes when it is free to load, so
    // a stalled product and tag stay frozen until the consumer takes them.
    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_product_d = s2_product_q;
        s2_tag_d     = s2_tag_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_product_d = s1_zero_q ? '0 : shifted;
                s2_tag_d     = s1_tag_q;
            end
        end
    end

    // Pipeline registers; reset drops every in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_e_q       <= '0;
            s1_mant_q    <= '0;
            s1_zero_q    <= 1'b0;
            s1_tag_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_product_q <= '0;
            s2_tag_q     <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_e_q       <= s1_e_d;
            s1_mant_q    <= s1_mant_d;
            s1_zero_q    <= s1_zero_d;
            s1_tag_q     <= s1_tag_d;
            s2_valid_q   <= s2_valid_d;
            s2_product_q <= s2_product_d;
            s2_tag_q     <= s2_tag_d;
        end
    end

    always_comb begin
        out_valid   = s2_valid_q;
        out_product = s2_product_q;
        out_tag     = s2_tag_q;
    end

endmodule

// File: tb/tb_log_antilog_stage.sv
// ---------------------------------------------------------------------------
// tb_log_antilog_stage
//
// Directed bench for log_antilog_stage (DWIDTH=16, M_WIDTH=6, TAG_WIDTH=4).
// Inputs are driven on the falling edge and outputs sampled 1 time unit
// later; a scoreboard of expected products/tags follows every handshake.
// ---------------------------------------------------------------------------
module tb_log_antilog_stage;

    localparam int DW = 16;
    localparam int MW = 6;
    localparam int TW = 4;
    localparam int KW = $clog2(DW) + 1;

    typedef struct {
        logic [2*DW-1:0] prod;
        logic [TW-1:0]   tag;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [KW-1:0]   in_sum_k;
    logic [MW:0]     in_sum_x;
    logic            in_zero;
    logic [TW-1:0]   in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] out_product;
    logic [TW-1:0]   out_tag;

    exp_t            sb[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    int              cyc      = 0;
    int              occ      = 0;
    int              out_count = 0;
    int              acc_count = 0;
    bit              held_valid = 1'b0;
    logic [2*DW-1:0] held_prod;
    logic [TW-1:0]   held_tag;
    logic            last_out_valid;
    logic [2*DW-1:0] last_prod;
    logic [TW-1:0]   last_tag;

    always #5 clk = ~clk;

    log_antilog_stage #(
        .DWIDTH   (DW),
        .M_WIDTH  (MW),
        .TAG_WIDTH(TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum_k   (in_sum_k),
        .in_sum_x   (in_sum_x),
        .in_zero    (in_zero),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product),
        .out_tag    (out_tag)
    );

    // Reference: product = (1 + frac) * 2^E with the carry folded into E,
    // evaluated with integer multiply/divide and truncated toward zero.
    function automatic logic [2*DW-1:0] refProduct(input int k, input int x, input bit z);
        longint e;
        longint mant;
        longint p;
        if (z) return '0;
        e    = longint'(k) + longint'((x >> MW) & 1);
        mant = 64 + longint'(x % 64);
        if (e >= MW) p = mant * (longint'(1) << (e - MW));
        else         p = mant / (longint'(1) << (MW - e));
        return p[2*DW-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, obs, expv, cyc);
        end
    endtask

    // One clock cycle: drive inputs, then check handshake, stability and
    // scoreboard against what the DUT shows in this cycle.
    task automatic applyStimulus(input bit v, input int k, input int x, input bit z,
                                 input int tg, input bit rdy, output bit accepted);
        exp_t e;
        in_valid  = v;
        in_sum_k  = KW'(k);
        in_sum_x  = (MW+1)'(x);
        in_zero   = z;
        in_tag    = TW'(tg);
        out_ready = rdy;
        #1;
        checkOutput("in_ready", {63'd0, in_ready}, {63'd0, (occ < 2) || rdy});
        if (held_valid) begin
            checkOutput("stall_valid", {63'd0, out_valid}, 64'd1);
            checkOutput("stall_prod", {32'd0, out_product}, {32'd0, held_prod});
            checkOutput("stall_tag", {60'd0, out_tag}, {60'd0, held_tag});
        end
        held_valid = 1'b0;
        accepted   = v && in_ready;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_out", {63'd0, out_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("product", {32'd0, out_product}, {32'd0, e.prod});
                checkOutput("tag", {60'd0, out_tag}, {60'd0, e.tag});
                occ--;
            end
            out_count++;
        end else if (out_valid) begin
            held_valid = 1'b1;
            held_prod  = out_product;
            held_tag   = out_tag;
        end
        if (accepted) begin
            e.prod = refProduct(k, x, z);
            e.tag  = TW'(tg);
            sb.push_back(e);
            occ++;
            acc_count++;
        end
        last_out_valid = out_valid;
        last_prod      = out_product;
        last_tag       = out_tag;
        @(negedge clk);
        cyc++;
    endtask

    // Single isolated transaction with a hand-computed product; checks the
    // two-cycle latency as well.
    task automatic runDirected(input string name, input int k, input int x, input bit z,
                               input int tg, input logic [2*DW-1:0] expProd);
        bit acc;
        applyStimulus(1'b1, k, x, z, tg, 1'b1, acc);
        checkOutput({name, "_accept"}, {63'd0, acc}, 64'd1);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b1, acc);
        checkOutput({name, "_lat1_valid"}, {63'd0, last_out_valid}, 64'd0);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b1, acc);
        checkOutput({name, "_lat2_valid"}, {63'd0, last_out_valid}, 64'd1);
        checkOutput({name, "_prod"}, {32'd0, last_prod}, {32'd0, expProd});
        checkOutput({name, "_tag"}, {60'd0, last_tag}, {60'd0, TW'(tg)});
    endtask

    task automatic resetDut(input int cycles);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum_k  = '0;
        in_sum_x  = '0;
        in_zero   = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (cycles) @(negedge clk);
        rst        = 1'b0;
        sb.delete();
        occ        = 0;
        held_valid = 1'b0;
        #1;
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_out_product", {32'd0, out_product}, 64'd0);
        checkOutput("rst_out_tag", {60'd0, out_tag}, 64'd0);
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        int idx;
        int base_out;
        int base_acc;
        int c0;

        @(negedge clk);
        resetDut(2);

        // Directed values with hand-computed products
        runDirected("d3x5", 3, 49, 1'b0, 1, 32'd14);
        runDirected("d3x3carry", 2, 65, 1'b0, 2, 32'd8);
        runDirected("dmax", 30, 127, 1'b0, 3, 32'hFE00_0000);
        runDirected("d1x1", 0, 1, 1'b0, 4, 32'd1);
        runDirected("dzero", 17, 100, 1'b1, 5, 32'd0);
        runDirected("deqm", 6, 5, 1'b0, 6, 32'd69);

        // Backpressure: tags 0..7, consumer stalls for 5 cycles mid-stream
        base_out = out_count;
        idx = 0;
        for (int c = 0; c < 60 && (idx < 8 || occ > 0); c++) begin
            applyStimulus(idx < 8, 2 + idx, 10 * idx + 5, 1'b0, idx,
                          !(c >= 3 && c < 8), acc);
            if (acc) idx++;
        end
        checkOutput("bp_all_accepted", 64'(idx), 64'd8);
        checkOutput("bp_out_count", 64'(out_count - base_out), 64'd8);
        checkOutput("bp_drained", 64'(sb.size()), 64'd0);

        // Reset with both stages full
        applyStimulus(1'b1, 5, 33, 1'b0, 9, 1'b0, acc);
        applyStimulus(1'b1, 7, 90, 1'b0, 10, 1'b0, acc);
        applyStimulus(1'b1, 8, 11, 1'b0, 11, 1'b0, acc);
        checkOutput("full_no_accept", {63'd0, acc}, 64'd0);
        resetDut(1);
        base_out = out_count;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b1, acc);
        end
        checkOutput("post_rst_no_output", 64'(out_count - base_out), 64'd0);

        // Throughput: 100 random inputs back to back, consumer always ready
        base_out = out_count;
        base_acc = acc_count;
        c0 = cyc;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, int'($urandom_range(0, 30)), int'($urandom_range(1, 127)),
                          ($urandom_range(0, 7) == 0), i % 16, 1'b1, acc);
        end
        checkOutput("tp_accepts", 64'(acc_count - base_acc), 64'd100);
        while (cyc <= c0 + 101) begin
            applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b1, acc);
        end
        checkOutput("tp_outputs", 64'(out_count - base_out), 64'd100);
        checkOutput("tp_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
